uart_rx_word_packer: RTL and testbench
======================================

UART_RX_WORD_PACKER -- requirements
Module: uart_rx_word_packer

Interface
REQ-001 Parameter DEPTH, default 8, word FIFO depth; power of two, 2..64.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 rdata  input  8  received byte from the UART receiver.
REQ-005 rdata_ready  input  1  one-cycle pulse, rdata/ferr valid.
REQ-006 ferr  input  1  framing error for the byte flagged by rdata_ready.
REQ-007 flush  input  1  synchronous clear of FIFO and partial word.
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 wdata  output  32  head-of-FIFO word.
REQ-010 wvalid  output  1  FIFO non-empty.
REQ-011 wready  input  1  consumer accepts wdata when wvalid&wready.
REQ-012 count  output  $clog2(DEPTH)+1  words held.
REQ-013 byte_cnt  output  2  bytes of current partial word.
REQ-014 ovf_err  output  1  sticky: completed word lost to full FIFO.
REQ-015 fr_err  output  1  sticky: byte dropped for framing error.

Function
REQ-016 No backpressure on the byte side; every rdata_ready pulse is processed in its cycle.
REQ-017 Packing little-endian: byte k (k=0..3) of a word lands in wdata[8k+7:8k].
REQ-018 Byte collector states: B0, B1, B2, B3 (byte_cnt = 0..3); good byte advances Bn->Bn+1; good byte in B3 completes the word and returns to B0.
REQ-019 Good byte = rdata_ready&~ferr; ferr byte is discarded, collector returns to B0, partial bytes discarded, fr_err set.
REQ-020 Completed word written to FIFO on the edge receiving the 4th byte; wvalid high on the following cycle (latency 1 clk from 4th pulse).
REQ-021 Completed word with FIFO full and no pop that cycle: word dropped, ovf_err set, collector to B0, FIFO unchanged.
REQ-022 Full FIFO with simultaneous pop (wvalid&wready) and completed word: both performed, count unchanged.
REQ-023 Pop: wvalid&wready advances head; wdata shows next word on following cycle; wready ignored when wvalid=0.
REQ-024 Simultaneous push and pop on non-empty, non-full FIFO: count unchanged, order preserved.
REQ-025 Pointers wrap modulo DEPTH; count = DEPTH means full, 0 means empty.
REQ-026 flush: count->0, collector->B0, incoming byte and pop that cycle ignored; sticky flags unaffected.
REQ-027 clr_err clears ovf_err and fr_err; a set event in the same cycle wins (flag stays 1).
REQ-028 wdata undefined-safe: holds last head value when empty, no X propagation after reset.

Reset
REQ-029 rstn low asynchronously forces: count=0, wvalid=0, byte_cnt=0, ovf_err=0, fr_err=0, wdata=0, pointers=0.
REQ-030 Reset mid-word or mid-pop discards all state; first rdata_ready after release is byte 0.
REQ-031 FIFO storage array needs no reset.

Structure
REQ-032 Shared package uart_pkg holds BYTES_PER_WORD=4, typedef word_t (logic[31:0]), typedef byte_t (logic[7:0]).
REQ-033 FIFO implemented as sub-module uart_word_fifo (DEPTH, push/pop/full/empty/count); packer logic in top.
REQ-034 Target size 150-300 lines RTL total.

Verification
REQ-035 Bytes 0x11,0x22,0x33,0x44 pulsed -> wdata=0x44332211, wvalid rises 1 clk after 4th pulse, count=1.
REQ-036 Bytes 0xAA,0xBB, then 0xCC with ferr=1, then 0x01..0x04 -> single word 0x04030201, fr_err=1, byte_cnt=0 after ferr.
REQ-037 DEPTH=8, wready=0, 9 words sent -> count=8, ovf_err=1, head still word 1; clr_err -> ovf_err=0.
REQ-038 FIFO full, wready=1 in same cycle as 4th byte of word 9 -> no ovf_err, count stays 8, word 9 at tail.
REQ-039 2 bytes then rstn low 1 clk mid-cycle -> all outputs 0 asynchronously; next 4 bytes 0x0A0B0C0D order form 0x0D0C0B0A.
REQ-040 3 words queued, flush with concurrent 4th byte and wready=1 -> count=0, wvalid=0, byte_cnt=0, sticky flags unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types for the UART receive word packer.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } coll_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_word_fifo
// Purpose  : Word FIFO with push/pop/flush; output holds last head when empty.
// Revision : 1.0
// ============================================================================
module uart_word_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  word_t                    push_data,
  input  logic                     pop,
  output word_t                    rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  word_t         last_q, last_d;
  word_t         mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty & ~flush;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push & ~flush & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = empty ? last_q : mem_q[rd_ptr_q];
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Storage is only read while occupied, so unreset entries never reach rdata.
  assign rdata = empty ? last_q : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_word_packer
// Purpose  : Packs received UART bytes little-endian into 32-bit FIFO words.
// Revision : 1.0
// ============================================================================
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  byte_t                    rdata,
  input  logic                     rdata_ready,
  input  logic                     ferr,
  input  logic                     flush,
  input  logic                     clr_err,
  output word_t                    wdata,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               byte_cnt,
  output logic                     ovf_err,
  output logic                     fr_err
);

  localparam int PW = (BYTES_PER_WORD - 1) * 8;

  coll_state_e   state_q, state_d;
  logic [PW-1:0] partial_q, partial_d;
  logic          ovf_q, ovf_d;
  logic          fr_q, fr_d;

  logic good_byte, bad_byte, word_done, pop_req, ovf_set;
  logic fifo_full, fifo_empty;

  assign good_byte = rdata_ready & ~ferr & ~flush;
  assign bad_byte  = rdata_ready &  ferr & ~flush;
  assign pop_req   = wvalid & wready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= B0;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush || bad_byte)
      state_d = B0;
    else if (good_byte)
      state_d = (state_q == B3) ? B0 : coll_state_e'(state_q + 2'd1);
  end

  // Output logic
  always_comb begin
    byte_cnt  = state_q;
    word_done = good_byte & (state_q == B3);
  end

  always_comb begin
    partial_d = partial_q;
    if (good_byte) begin
      case (state_q)
        B0:      partial_d[7:0]   = rdata;
        B1:      partial_d[15:8]  = rdata;
        B2:      partial_d[23:16] = rdata;
        default: partial_d        = partial_q;
      endcase
    end
  end

  // A word is lost only if the FIFO is full and the head is not leaving.
  assign ovf_set = word_done & fifo_full & ~(pop_req & ~fifo_empty);

  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | ovf_set;
    fr_d  = (fr_q  & ~clr_err) | bad_byte;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      partial_q <= '0;
      ovf_q     <= 1'b0;
      fr_q      <= 1'b0;
    end else begin
      partial_q <= partial_d;
      ovf_q     <= ovf_d;
      fr_q      <= fr_d;
    end
  end

  uart_word_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .push      (word_done),
    .push_data ({rdata, partial_q}),
    .pop       (pop_req),
    .rdata     (wdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign wvalid  = ~fifo_empty;
  assign ovf_err = ovf_q;
  assign fr_err  = fr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_word_packer
// Purpose  : Directed self-checking bench for uart_rx_word_packer.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_word_packer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rdata = '0;
  logic        rdata_ready = 1'b0;
  logic        ferr = 1'b0;
  logic        flush = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [3:0]  count;
  logic [1:0]  byte_cnt;
  logic        ovf_err;
  logic        fr_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_rx_word_packer #(.DEPTH(8)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rdata       (rdata),
    .rdata_ready (rdata_ready),
    .ferr        (ferr),
    .flush       (flush),
    .clr_err     (clr_err),
    .wdata       (wdata),
    .wvalid      (wvalid),
    .wready      (wready),
    .count       (count),
    .byte_cnt    (byte_cnt),
    .ovf_err     (ovf_err),
    .fr_err      (fr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge so each pulse spans exactly one rising edge.
  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clk);
    rdata = b; ferr = fe; rdata_ready = 1'b1;
    @(negedge clk);
    rdata_ready = 1'b0; ferr = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
  endtask

  task automatic pop_one;
    @(negedge clk); wready = 1'b1;
    @(negedge clk); wready = 1'b0;
  endtask

  task automatic pulse_clr;
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    #12;
    check("rst_count",  {28'd0, count},    32'd0);
    check("rst_wvalid", {31'd0, wvalid},   32'd0);
    check("rst_wdata",  wdata,             32'd0);
    check("rst_bytecnt",{30'd0, byte_cnt}, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Basic packing and one-cycle latency
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    check("bc_3", {30'd0, byte_cnt}, 32'd3);
    @(negedge clk); rdata = 8'h44; rdata_ready = 1'b1;
    check("wvalid_pre", {31'd0, wvalid}, 32'd0);
    @(negedge clk); rdata_ready = 1'b0;
    check("w1_wdata",  wdata, 32'h44332211);
    check("w1_wvalid", {31'd0, wvalid}, 32'd1);
    check("w1_count",  {28'd0, count},  32'd1);
    check("w1_bc",     {30'd0, byte_cnt}, 32'd0);
    pop_one();
    check("pop_empty", {31'd0, wvalid}, 32'd0);
    check("pop_hold",  wdata, 32'h44332211);

    // Framing error discards partial word
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    send_byte(8'hCC, 1);
    check("fe_bc",  {30'd0, byte_cnt}, 32'd0);
    check("fe_flag",{31'd0, fr_err},   32'd1);
    send_word(32'h04030201);
    check("fe_word",  wdata, 32'h04030201);
    check("fe_count", {28'd0, count}, 32'd1);
    pop_one();
    pulse_clr();
    check("fe_clr", {31'd0, fr_err}, 32'd0);

    // Overflow with no consumer
    for (int i = 1; i <= 9; i++) send_word(32'h01010101 * i);
    check("ovf_count", {28'd0, count},   32'd8);
    check("ovf_flag",  {31'd0, ovf_err}, 32'd1);
    check("ovf_head",  wdata, 32'h01010101);
    pulse_clr();
    check("ovf_clr",   {31'd0, ovf_err}, 32'd0);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("ovf_drain%0d", i), wdata, 32'h01010101 * i);
      pop_one();
    end
    check("ovf_empty", {31'd0, wvalid}, 32'd0);

    // Full FIFO with simultaneous pop and push
    for (int i = 1; i <= 8; i++) send_word(32'h01010101 * i);
    w = 32'h09090909;
    for (int k = 0; k < 3; k++) send_byte(w[8*k +: 8], 0);
    @(negedge clk); rdata = w[31:24]; rdata_ready = 1'b1; wready = 1'b1;
    @(negedge clk); rdata_ready = 1'b0; wready = 1'b0;
    check("fp_ovf",   {31'd0, ovf_err}, 32'd0);
    check("fp_count", {28'd0, count},   32'd8);
    for (int i = 2; i <= 9; i++) begin
      check($sformatf("fp_drain%0d", i), wdata, 32'h01010101 * i);
      pop_one();
    end

    // Flush with concurrent 4th byte and pop
    send_byte(8'h55, 1);
    for (int i = 1; i <= 3; i++) send_word(32'h10203040 + i);
    send_byte(8'hE0, 0); send_byte(8'hE1, 0); send_byte(8'hE2, 0);
    @(negedge clk); rdata = 8'hE3; rdata_ready = 1'b1; wready = 1'b1; flush = 1'b1;
    @(negedge clk); rdata_ready = 1'b0; wready = 1'b0; flush = 1'b0;
    check("fl_count", {28'd0, count},    32'd0);
    check("fl_wvalid",{31'd0, wvalid},   32'd0);
    check("fl_bc",    {30'd0, byte_cnt}, 32'd0);
    check("fl_fr",    {31'd0, fr_err},   32'd1);
    check("fl_ovf",   {31'd0, ovf_err},  32'd0);
    send_word(32'hCAFEF00D);
    check("fl_next", wdata, 32'hCAFEF00D);

    // Asynchronous reset mid-word
    send_byte(8'h77, 0); send_byte(8'h88, 0);
    @(negedge clk); #2 rstn = 1'b0; #1;
    check("ar_count",  {28'd0, count},    32'd0);
    check("ar_wvalid", {31'd0, wvalid},   32'd0);
    check("ar_wdata",  wdata,             32'd0);
    check("ar_bc",     {30'd0, byte_cnt}, 32'd0);
    check("ar_fr",     {31'd0, fr_err},   32'd0);
    @(negedge clk); rstn = 1'b1;
    send_byte(8'h0A, 0); send_byte(8'h0B, 0); send_byte(8'h0C, 0); send_byte(8'h0D, 0);
    check("ar_word",  wdata, 32'h0D0C0B0A);
    check("ar_count1",{28'd0, count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
